// File: rtl/tdm_demux_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tdm_pkg                                                     |
// | Desc   : Shared types/constants for the TDM demultiplexer.           |
// |          TDM_DEMUX_PARITY_EN adds an even-parity bit to each slot.   |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package tdm_pkg;

    localparam int NCH_DEFAULT = 4;
    localparam int W_DEFAULT   = 8;

`ifdef TDM_DEMUX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    typedef enum logic [0:0] {
        HUNT = 1'b0,
        SYNC = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/tdm_demux_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tdm_demux_if                                                |
// | Desc   : Serial TDM input and per-channel output bundle.             |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
interface tdm_demux_if
    import tdm_pkg::*;
#(
    parameter int NCH = NCH_DEFAULT,
    parameter int W   = W_DEFAULT
);
    logic             din;
    logic             din_vld;
    logic             fsync;
    logic [NCH*W-1:0] ch_data;
    logic [NCH-1:0]   ch_vld;
    logic             lock;
    logic             frame_err;
    logic             par_err;

    modport master (
        output din, din_vld, fsync,
        input  ch_data, ch_vld, lock, frame_err, par_err
    );

    modport slave (
        input  din, din_vld, fsync,
        output ch_data, ch_vld, lock, frame_err, par_err
    );
endinterface
`default_nettype wire

// File: rtl/tdm_demux_deser.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tdm_deser                                                   |
// | Desc   : Slot shift register, bit counter and slot-done strobe.      |
// |          TDM_DEMUX_PARITY_EN extends a slot by one parity bit.       |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tdm_deser
    import tdm_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         din_i,
    input  wire logic         take_i,
    input  wire logic         restart_i,
    input  wire logic         clear_i,
    output logic              first_o,
    output logic              done_o,
`ifdef TDM_DEMUX_PARITY_EN
    output logic              par_bit_o,
`endif
    output logic [W-1:0]      word_o
);
    localparam int SB  = W + PAR_BITS;
    localparam int SRW = SB - 1;
    localparam int CW  = $clog2(SB + 1);
    localparam logic [CW-1:0] LAST = CW'(SB - 1);

    logic [CW-1:0]  cnt_q, cnt_d;
    logic [SRW-1:0] sr_q, sr_d;
    logic           last_bit;

    assign last_bit = (cnt_q == LAST);
    assign first_o  = (cnt_q == '0);
    assign done_o   = take_i && !restart_i && !clear_i && last_bit;

    // The register keeps the last SB-1 bits; the bit on the wire completes the slot.
`ifdef TDM_DEMUX_PARITY_EN
    assign word_o    = sr_q;
    assign par_bit_o = din_i;
`else
    assign word_o    = {sr_q, din_i};
`endif

    always_comb begin
        cnt_d = cnt_q;
        sr_d  = sr_q;
        if (clear_i) begin
            cnt_d = '0;
            sr_d  = '0;
        end else if (take_i) begin
            sr_d = SRW'({sr_q, din_i});
            if (restart_i) begin
                cnt_d = CW'(1);
            end else if (last_bit) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            sr_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            sr_q  <= sr_d;
        end
    end
endmodule
`default_nettype wire

// File: rtl/tdm_demux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tdm_demux                                                   |
// | Desc   : Serial TDM frame demultiplexer with HUNT/SYNC framing.      |
// |          TDM_DEMUX_PARITY_EN enables per-slot even parity checking.  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int NCH = NCH_DEFAULT,
    parameter int W   = W_DEFAULT
) (
    input  wire logic  clk,
    input  wire logic  rst,
    tdm_demux_if.slave bus
);
    localparam int SW = $clog2(NCH);
    localparam logic [SW-1:0] LAST_SLOT = SW'(NCH - 1);

    state_t           state_q;
    logic [SW-1:0]    slot_q;
    logic [NCH*W-1:0] ch_data_q;
    logic [NCH-1:0]   ch_vld_q;
    logic             frame_err_q;
    logic             take, restart, clear, first, done, slot_start;
    logic [W-1:0]     word;
`ifdef TDM_DEMUX_PARITY_EN
    logic             par_bit;
    logic             par_err_q;
`endif

    assign slot_start = first && (slot_q == '0);

    always_comb begin
        take    = 1'b0;
        restart = 1'b0;
        clear   = 1'b0;
        if (bus.din_vld) begin
            if (state_q == HUNT) begin
                take    = bus.fsync;
                restart = bus.fsync;
            end else if (slot_start) begin
                take  = bus.fsync;
                clear = !bus.fsync;
            end else begin
                // fsync mid-frame realigns: this bit becomes the slot-0 MSB
                take    = 1'b1;
                restart = bus.fsync;
            end
        end
    end

    tdm_deser #(.W(W)) u_deser (
        .clk       (clk),
        .rst       (rst),
        .din_i     (bus.din),
        .take_i    (take),
        .restart_i (restart),
        .clear_i   (clear),
        .first_o   (first),
        .done_o    (done),
`ifdef TDM_DEMUX_PARITY_EN
        .par_bit_o (par_bit),
`endif
        .word_o    (word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HUNT;
            slot_q      <= '0;
            ch_data_q   <= '0;
            ch_vld_q    <= '0;
            frame_err_q <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            ch_vld_q    <= '0;
            frame_err_q <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            par_err_q   <= 1'b0;
`endif
            if (bus.din_vld) begin
                if (state_q == HUNT) begin
                    if (bus.fsync) begin
                        state_q <= SYNC;
                        slot_q  <= '0;
                    end
                end else if (bus.fsync != slot_start) begin
                    frame_err_q <= 1'b1;
                    slot_q      <= '0;
                    if (!bus.fsync) begin
                        state_q <= HUNT;
                    end
                end else if (done) begin
                    slot_q <= (slot_q == LAST_SLOT) ? '0 : slot_q + 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
                    if (par_bit == ^word) begin
                        ch_data_q[int'(slot_q)*W +: W] <= word;
                        ch_vld_q[slot_q]               <= 1'b1;
                    end else begin
                        par_err_q <= 1'b1;
                    end
`else
                    ch_data_q[int'(slot_q)*W +: W] <= word;
                    ch_vld_q[slot_q]               <= 1'b1;
`endif
                end
            end
        end
    end

    assign bus.ch_data   = ch_data_q;
    assign bus.ch_vld    = ch_vld_q;
    assign bus.lock      = (state_q == SYNC);
    assign bus.frame_err = frame_err_q;
`ifdef TDM_DEMUX_PARITY_EN
    assign bus.par_err   = par_err_q;
`else
    assign bus.par_err   = 1'b0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_tdm_demux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_tdm_demux                                                |
// | Desc   : Directed and random bench for tdm_demux against a queue     |
// |          model. Honours TDM_DEMUX_PARITY_EN.                         |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_tdm_demux;
    localparam int NCH = 4;
    localparam int W   = 8;
`ifdef TDM_DEMUX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int SB = W + PB;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tdm_demux_if #(.NCH(NCH), .W(W)) bus ();
    tdm_demux #(.NCH(NCH), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Model: frame state as "in sync", slot index and the bits of the open slot
    bit             m_sync;
    int             m_slot;
    bit             m_bits[$];
    logic [W-1:0]   m_data [NCH];
    logic [NCH-1:0] m_vld;
    bit             m_ferr, m_perr;

    int checks   = 0;
    int failures = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_sync = 1'b0;
        m_slot = 0;
        m_bits.delete();
        m_vld  = '0;
        m_ferr = 1'b0;
        m_perr = 1'b0;
        for (int i = 0; i < NCH; i++) m_data[i] = '0;
    endfunction

    function automatic void model_step(bit d, bit v, bit f);
        bit           start;
        bit           ok;
        logic [W-1:0] word;
        m_vld  = '0;
        m_ferr = 1'b0;
        m_perr = 1'b0;
        if (!v) return;
        if (!m_sync) begin
            if (f) begin
                m_sync = 1'b1;
                m_slot = 0;
                m_bits.delete();
                m_bits.push_back(d);
            end
            return;
        end
        start = (m_bits.size() == 0) && (m_slot == 0);
        if (start && !f) begin
            m_ferr = 1'b1;
            m_sync = 1'b0;
            return;
        end
        if (f && !start) begin
            m_ferr = 1'b1;
            m_slot = 0;
            m_bits.delete();
            m_bits.push_back(d);
            return;
        end
        m_bits.push_back(d);
        if (m_bits.size() == SB) begin
            word = '0;
            for (int i = 0; i < W; i++) word = (word << 1) | W'(m_bits[i]);
            ok = 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
            ok = ((^word) == m_bits[W]);
`endif
            if (ok) begin
                m_data[m_slot] = word;
                m_vld[m_slot]  = 1'b1;
            end else begin
                m_perr = 1'b1;
            end
            m_bits.delete();
            m_slot = (m_slot + 1) % NCH;
        end
    endfunction

    task automatic check_all();
        logic [NCH*W-1:0] exp_data;
        for (int i = 0; i < NCH; i++) exp_data[i*W +: W] = m_data[i];
        chk("ch_data",   64'(bus.ch_data),   64'(exp_data));
        chk("ch_vld",    64'(bus.ch_vld),    64'(m_vld));
        chk("lock",      64'(bus.lock),      64'(m_sync));
        chk("frame_err", 64'(bus.frame_err), 64'(m_ferr));
        chk("par_err",   64'(bus.par_err),   64'(m_perr));
    endtask

    task automatic cyc(bit d, bit v, bit f);
        bus.din     = d;
        bus.din_vld = v;
        bus.fsync   = f;
        @(posedge clk);
        if (rst) model_reset();
        else     model_step(d, v, f);
        #1 check_all();
    endtask

    // Idle cycles (slow) carry random din/fsync that must be ignored.
    task automatic send_slot(logic [W-1:0] val, bit fs, bit bad_par, bit slow);
        for (int i = W - 1; i >= 0; i--) begin
            if (slow) cyc(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
            cyc(val[i], 1'b1, (i == W - 1) ? fs : 1'b0);
        end
`ifdef TDM_DEMUX_PARITY_EN
        if (slow) cyc(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
        cyc((^val) ^ bad_par, 1'b1, 1'b0);
`else
        if (bad_par) $display("note: parity not enabled");
`endif
    endtask

    task automatic frame(logic [W-1:0] v0, logic [W-1:0] v1, logic [W-1:0] v2,
                         logic [W-1:0] v3, bit slow);
        logic [W-1:0] vals [NCH];
        vals[0] = v0; vals[1] = v1; vals[2] = v2; vals[3] = v3;
        for (int n = 0; n < NCH; n++) begin
            send_slot(vals[n], n == 0, 1'b0, slow);
            chk("frame_vld",  64'(bus.ch_vld), 64'(1 << n));
            chk("frame_data", 64'(bus.ch_data[n*W +: W]), 64'(vals[n]));
        end
    endtask

    initial begin
        int pos;
        rst         = 1'b1;
        bus.din     = 1'b0;
        bus.din_vld = 1'b0;
        bus.fsync   = 1'b0;
        model_reset();

        // reset holds everything at zero even with fsync strobing
        repeat (3) cyc(1'b1, 1'b1, 1'b1);
        chk("reset_lock", 64'(bus.lock), 64'd0);
        chk("reset_data", 64'(bus.ch_data), 64'd0);
        rst = 1'b0;
        cyc(1'b0, 1'b1, 1'b0);
        chk("hunt_lock", 64'(bus.lock), 64'd0);

        // clean frame
        cyc(1'b1, 1'b1, 1'b1);
        chk("lock_after_first_bit", 64'(bus.lock), 64'd1);
        for (int i = W - 2; i >= 0; i--) cyc(1'(8'hA5 >> i), 1'b1, 1'b0);
`ifdef TDM_DEMUX_PARITY_EN
        cyc(^8'hA5, 1'b1, 1'b0);
`endif
        chk("slot0_vld", 64'(bus.ch_vld), 64'd1);
        for (int n = 1; n < NCH; n++) begin
            send_slot((n == 1) ? 8'h3C : (n == 2) ? 8'hFF : 8'h01, 1'b0, 1'b0, 1'b0);
            chk("slot_vld", 64'(bus.ch_vld), 64'(1 << n));
        end
        chk("frame1_data", 64'(bus.ch_data), 64'h01FF3CA5);

        // missing fsync at next slot-0 MSB
        cyc(1'b0, 1'b1, 1'b0);
        chk("nofs_ferr", 64'(bus.frame_err), 64'd1);
        chk("nofs_lock", 64'(bus.lock), 64'd0);
        repeat (20) cyc(1'($urandom_range(0, 1)), 1'b1, 1'b0);
        chk("nofs_hold", 64'(bus.ch_data), 64'h01FF3CA5);

        // stray fsync at bit 3 of slot 2
        send_slot(8'h11, 1'b1, 1'b0, 1'b0);
        send_slot(8'h22, 1'b0, 1'b0, 1'b0);
        repeat (3) cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        chk("stray_ferr", 64'(bus.frame_err), 64'd1);
        chk("stray_vld",  64'(bus.ch_vld), 64'd0);
        chk("stray_lock", 64'(bus.lock), 64'd1);
        for (int i = W - 2; i >= 0; i--) cyc(1'(8'h77 >> i), 1'b1, 1'b0);
`ifdef TDM_DEMUX_PARITY_EN
        cyc(^8'h77, 1'b1, 1'b0);
`endif
        chk("stray_vld0",  64'(bus.ch_vld), 64'd1);
        chk("stray_data",  64'(bus.ch_data), 64'h01FF2277);
        send_slot(8'h01, 1'b0, 1'b0, 1'b0);
        send_slot(8'h02, 1'b0, 1'b0, 1'b0);
        send_slot(8'h03, 1'b0, 1'b0, 1'b0);

        // din_vld toggling
        frame(8'hA5, 8'h3C, 8'hFF, 8'h01, 1'b1);

        // async reset at bit 5 of slot 1
        send_slot(8'hC3, 1'b1, 1'b0, 1'b0);
        for (int i = W - 1; i >= W - 5; i--) cyc(1'(8'h5A >> i), 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1 model_reset();
        check_all();
        chk("async_rst_data", 64'(bus.ch_data), 64'd0);
        chk("async_rst_lock", 64'(bus.lock), 64'd0);
        repeat (2) cyc(1'b0, 1'b1, 1'b0);
        rst = 1'b0;
        cyc(1'b0, 1'b1, 1'b0);
        frame(8'hA5, 8'h66, 8'hFF, 8'h01, 1'b0);

`ifdef TDM_DEMUX_PARITY_EN
        send_slot(8'h11, 1'b1, 1'b0, 1'b0);
        send_slot(8'h3C, 1'b0, 1'b1, 1'b0);
        chk("par_err",  64'(bus.par_err), 64'd1);
        chk("par_vld",  64'(bus.ch_vld), 64'd0);
        chk("par_hold", 64'(bus.ch_data[W +: W]), 64'h66);
        chk("par_lock", 64'(bus.lock), 64'd1);
        send_slot(8'h22, 1'b0, 1'b0, 1'b0);
        send_slot(8'h33, 1'b0, 1'b0, 1'b0);
`endif

        // random traffic with occasional framing faults
        pos = 0;
        for (int n = 0; n < 4000; n++) begin
            bit v, f;
            v = ($urandom_range(0, 3) != 0);
            f = (pos == 0);
            if ($urandom_range(0, 99) < 3) f = !f;
            cyc(1'($urandom_range(0, 1)), v, v ? f : 1'($urandom_range(0, 1)));
            if (v) pos = (pos + 1) % (NCH * SB);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
